// File: rtl/leading_one_isolator_pkg.sv
// Shared constants and FSM encodings for the leading-one isolator.
// Define LEADING_ONE_INDEX_EN to add the out_index port and its index register.
package leading_one_isolator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/leading_one_isolator.sv
// Sequential MSB-first scanner producing a strictly one-hot mask (or zero flag) for the encoder.
// Optional out_index port is enabled by `define LEADING_ONE_INDEX_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for a word
// SCAN  | shifting the captured word left until its MSB is set
// DONE  | result held on out_* until out_ready
module leading_one_isolator
  import leading_one_isolator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_onehot,
  output logic                     out_zero
`ifdef LEADING_ONE_INDEX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] out_index
`endif
);

  localparam int IW = $clog2(WIDTH);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [IW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic             zero_q,   zero_d;
  logic             valid_q,  valid_d;
`ifdef LEADING_ONE_INDEX_EN
  logic [IW-1:0]    index_q,  index_d;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
`ifdef LEADING_ONE_INDEX_EN
    index_d  = index_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_data != '0) begin
            shreg_d = in_data;
            cnt_d   = IW'(WIDTH - 1);
            state_d = ST_SCAN;
          end else begin
            // Zero words skip the scan entirely so the loop never runs on an empty word.
            onehot_d = '0;
            zero_d   = 1'b1;
            valid_d  = 1'b1;
`ifdef LEADING_ONE_INDEX_EN
            index_d  = '0;
`endif
            state_d  = ST_DONE;
          end
        end
      end
      ST_SCAN: begin
        if (shreg_q[WIDTH-1]) begin
          onehot_d = WIDTH'(1) << cnt_q;
          zero_d   = 1'b0;
          valid_d  = 1'b1;
`ifdef LEADING_ONE_INDEX_EN
          index_d  = cnt_q;
`endif
          state_d  = ST_DONE;
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef LEADING_ONE_INDEX_EN
      index_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
`ifdef LEADING_ONE_INDEX_EN
      index_q  <= index_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = valid_q;
  assign out_onehot = onehot_q;
  assign out_zero   = zero_q;
`ifdef LEADING_ONE_INDEX_EN
  assign out_index  = index_q;
`endif

endmodule
